any1_regfile_mp: RTL

ANY1_REGFILE_MP -- requirements
Module: any1_regfile_mp

---
 rtl/any1_regfile_mp.sv | 113 +++++++++++
 1 files changed

// File: rtl/any1_regfile_mp.sv
// Multi-read-port register file with an init sweep, same-cycle write bypass
// and per-register pending (busy) tracking.
module any1_regfile_mp #(
  parameter int WID  = 80,
  parameter int AWID = 10,
  parameter int NRD  = 4,
  parameter int ZB   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0,
  input  logic [AWID-1:0]   wa0,
  input  logic [WID-1:0]    i0,
  input  logic              wr1,
  input  logic [AWID-1:0]   wa1,
  input  logic [WID-1:0]    i1,
  input  logic [NRD*AWID-1:0] ra,
  output logic [NRD*WID-1:0]  o,
  input  logic              iss,
  input  logic [AWID-1:0]   ita,
  output logic [NRD-1:0]    rbusy,
  output logic              rdy
);

  localparam int N = 2**AWID;

  typedef enum logic {INIT, RUN} st_t;

  st_t             st;
  logic [AWID-1:0] icnt;
  logic [WID-1:0]  mem [N];
  logic [N-1:0]    busy;
  logic [N-1:0]    busy_nx;
  logic            run;

  assign run = (st == RUN);

  function automatic logic zr(input logic [AWID-1:0] a);
    return a[ZB-1:0] == '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= INIT;
      icnt <= '0;
      rdy  <= 1'b0;
    end else if (!run) begin
      icnt <= icnt + AWID'(1);
      if (icnt == '1) begin
        st  <= RUN;
        rdy <= 1'b1;
      end
    end
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem[icnt] <= '0;
      end else begin
        if (wr0 && !zr(wa0))
          mem[wa0] <= i0;
        if (wr1 && !zr(wa1))
          mem[wa1] <= i1;
      end
    end
  end

  // Clears first, then the issue set, so a set beats a clear.
  always_comb begin
    busy_nx = busy;
    if (wr0)
      busy_nx[wa0] = 1'b0;
    if (wr1)
      busy_nx[wa1] = 1'b0;
    if (iss && !zr(ita))
      busy_nx[ita] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else if (run)
      busy <= busy_nx;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AWID-1:0] a;
    logic            h0;
    logic            h1;
    logic [WID-1:0]  d;

    assign a  = ra[k*AWID +: AWID];
    assign h0 = wr0 && (wa0 == a);
    assign h1 = wr1 && (wa1 == a);

    always_comb begin
      if (!run || zr(a))
        d = '0;
      else if (h1)
        d = i1;
      else if (h0)
        d = i0;
      else
        d = mem[a];
    end

    assign o[k*WID +: WID] = d;
    assign rbusy[k] = run && !zr(a) && busy[a] && !h0 && !h1;
  end

endmodule
